// File: rtl/axi_sram_slave_if.sv
// axi_sram_slave_if
// Bus bundle between an AXI-lite-style requester and the SRAM responder.
// Channels:
//   aw_*  write address   (aw_addr, aw_valid, aw_ready)
//   w_*   write data      (w_data, w_strb, w_valid, w_ready)
//   b_*   write response  (b_valid, b_ready)
//   ar_*  read address    (ar_addr, ar_valid, ar_ready)
//   r_*   read data       (r_data, r_valid, r_ready)
// Modports: master drives requests and response-readies; slave drives
// request-readies and responses.
interface axi_sram_slave_if;
  logic [63:0] aw_addr;
  logic        aw_valid;
  logic        aw_ready;
  logic [63:0] w_data;
  logic [7:0]  w_strb;
  logic        w_valid;
  logic        w_ready;
  logic        b_valid;
  logic        b_ready;
  logic [63:0] ar_addr;
  logic        ar_valid;
  logic        ar_ready;
  logic [63:0] r_data;
  logic        r_valid;
  logic        r_ready;

  modport master (
    output aw_addr, aw_valid, w_data, w_strb, w_valid, b_ready,
           ar_addr, ar_valid, r_ready,
    input  aw_ready, w_ready, b_valid, ar_ready, r_data, r_valid
  );

  modport slave (
    input  aw_addr, aw_valid, w_data, w_strb, w_valid, b_ready,
           ar_addr, ar_valid, r_ready,
    output aw_ready, w_ready, b_valid, ar_ready, r_data, r_valid
  );
endinterface

// File: rtl/axi_sram_slave.sv
// axi_sram_slave
// Single-outstanding AXI-lite-style memory responder with a byte-writable
// array of 64-bit words and fixed, parameterised read/write latencies.
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset (array contents are kept)
//   bus        axi_sram_slave_if.slave (AW/W/B/AR/R channels)
//   state_dbg  current FSM state (IDLE=0, RD_WAIT=1, RD_RESP=2,
//              WR_WAIT=3, WR_RESP=4)
//
// Handshake rules: a transfer happens on a rising edge where both valid and
// ready are high. Requesters hold valid and payload until ready; this block
// holds r_valid/b_valid and r_data stable until the matching ready. Readies
// are combinational from state and valids; responses are registered.
module axi_sram_slave #(
  parameter logic [63:0] ADDR_BASE   = 64'h8000_0000,
  parameter int          DEPTH_WORDS = 4096,  // power of two
  parameter int          RD_LATENCY  = 2,     // 1..15
  parameter int          WR_LATENCY  = 1      // 1..15
) (
  input  logic                clk,
  input  logic                rst_n,
  axi_sram_slave_if.slave     bus,
  output logic [2:0]          state_dbg
);

  localparam int          IDX_W   = $clog2(DEPTH_WORDS);
  localparam logic [63:0] SPAN    = 64'(DEPTH_WORDS) << 3;
  localparam logic [3:0]  RD_LOAD = 4'(RD_LATENCY - 1);
  localparam logic [3:0]  WR_LOAD = 4'(WR_LATENCY - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_WAIT = 3'd1,
    RD_RESP = 3'd2,
    WR_WAIT = 3'd3,
    WR_RESP = 3'd4
  } state_t;

  state_t      state, state_next;
  logic [3:0]  cnt;
  logic [63:0] r_data_q;
  logic        r_valid_q;
  logic        b_valid_q;

  logic        ar_ready, aw_ready;
  logic        rd_go, wr_go;

  logic [63:0] mem [DEPTH_WORDS];

  // Address decode; subtraction wraps so addresses below the base land far
  // above SPAN and decode as out of range.
  logic [63:0]      rd_off, wr_off;
  logic [IDX_W-1:0] rd_idx, wr_idx;
  logic             rd_in_range, wr_in_range;

  assign rd_off      = bus.ar_addr - ADDR_BASE;
  assign wr_off      = bus.aw_addr - ADDR_BASE;
  assign rd_idx      = rd_off[IDX_W+2:3];
  assign wr_idx      = wr_off[IDX_W+2:3];
  assign rd_in_range = rd_off < SPAN;
  assign wr_in_range = wr_off < SPAN;

  // Next state and readies
  always_comb begin
    state_next = state;
    ar_ready   = 1'b0;
    aw_ready   = 1'b0;
    rd_go      = 1'b0;
    wr_go      = 1'b0;
    case (state)
      IDLE: begin
        ar_ready = 1'b1;
        // Write needs address and data together; a pending read wins.
        aw_ready = bus.aw_valid && bus.w_valid && !bus.ar_valid;
        if (bus.ar_valid) begin
          rd_go      = 1'b1;
          state_next = (RD_LATENCY == 1) ? RD_RESP : RD_WAIT;
        end else if (aw_ready) begin
          wr_go      = 1'b1;
          state_next = (WR_LATENCY == 1) ? WR_RESP : WR_WAIT;
        end
      end
      RD_WAIT: if (cnt == 4'd1) state_next = RD_RESP;
      RD_RESP: if (bus.r_ready) state_next = IDLE;
      WR_WAIT: if (cnt == 4'd1) state_next = WR_RESP;
      WR_RESP: if (bus.b_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State, counter and response registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      r_data_q  <= 64'h0;
      r_valid_q <= 1'b0;
      b_valid_q <= 1'b0;
    end else begin
      state     <= state_next;
      r_valid_q <= (state_next == RD_RESP);
      b_valid_q <= (state_next == WR_RESP);
      if (rd_go) begin
        cnt      <= RD_LOAD;
        r_data_q <= rd_in_range ? mem[rd_idx] : 64'h0;
      end else if (wr_go) begin
        cnt <= WR_LOAD;
      end else if (state == RD_WAIT || state == WR_WAIT) begin
        cnt <= cnt - 4'd1;
      end
    end
  end

  // Array write at the handshake edge; not cleared by reset, and no write
  // is committed while reset is asserted.
  always_ff @(posedge clk) begin
    if (rst_n && wr_go && wr_in_range) begin
      for (int i = 0; i < 8; i++) begin
        if (bus.w_strb[i]) mem[wr_idx][8*i +: 8] <= bus.w_data[8*i +: 8];
      end
    end
  end

  assign bus.ar_ready = ar_ready;
  assign bus.aw_ready = aw_ready;
  assign bus.w_ready  = aw_ready;
  assign bus.r_data   = r_data_q;
  assign bus.r_valid  = r_valid_q;
  assign bus.b_valid  = b_valid_q;
  assign state_dbg    = state;

endmodule

// File: doc/axi_sram_slave.md
# axi_sram_slave

Single-port AXI-lite-style responder that terminates the memory side of the SRAM arbiter and serves both the instruction-fetch and load/store masters. It accepts one read or one write transaction at a time, keeps a byte-writable 64-bit word array, and returns read data or a write acknowledge after a programmable fixed latency. It serves as the synthesizable memory model behind the arbiter in simulation, and as the behavioural reference for latency and backpressure testing.

## Interface
Parameters:
- ADDR_BASE, 64'h8000_0000, byte address that maps to word 0
- DEPTH_WORDS, 4096, number of 64-bit words; must be a power of two
- RD_LATENCY, 2, cycles from AR handshake to R_VALID; legal range 1..15
- WR_LATENCY, 1, cycles from AW/W handshake to B_VALID; legal range 1..15

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, synchronous, active-low
- AW_ADDR  in  64  write byte address
- AW_VALID  in  1  write address valid
- AW_READY  out  1  write address accepted
- W_DATA  in  64  write data
- W_STRB  in  8  byte enables; bit i enables W_DATA[8i+7:8i]
- W_VALID  in  1  write data valid
- W_READY  out  1  write data accepted
- B_VALID  out  1  write response valid
- B_READY  in  1  write response accepted
- AR_ADDR  in  64  read byte address
- AR_VALID  in  1  read address valid
- AR_READY  out  1  read address accepted
- R_DATA  out  64  read data
- R_VALID  out  1  read data valid
- R_READY  in  1  read data accepted

## Operation
- FSM states: IDLE, RD_WAIT, RD_RESP, WR_WAIT, WR_RESP.
- Address decode: off = ADDR - ADDR_BASE (64-bit wrap). idx = off[3+log2(DEPTH_WORDS)-1:3]. ADDR[2:0] is ignored. If off >= DEPTH_WORDS*8, the access is out of range.
- IDLE:
  - AR_READY = 1.
  - AW_READY = W_READY = AW_VALID && W_VALID && !AR_VALID. A write is accepted only when address and data are both present.
  - Reads have priority when AR_VALID and AW_VALID are both high.
- Read handshake (AR_VALID && AR_READY):
  - Latch the array word, or 64'h0 if out of range, into the R_DATA register.
  - Load the counter with RD_LATENCY-1.
  - Go to RD_RESP if RD_LATENCY==1, else RD_WAIT.
- RD_WAIT: decrement the counter each cycle. When the counter reaches 1, the next state is RD_RESP.
- RD_RESP: R_VALID = 1. R_DATA is held stable until R_READY. On R_VALID && R_READY, go to IDLE.
- Write handshake:
  - The array is updated at that same clock edge, for the enabled bytes only.
  - Out-of-range writes are dropped silently.
  - Load the counter with WR_LATENCY-1.
  - Go to WR_RESP if WR_LATENCY==1, else WR_WAIT.
- WR_WAIT / WR_RESP mirror the read path. B_VALID = 1 in WR_RESP. On B_VALID && B_READY, go to IDLE.
- Outside IDLE: AR_READY = AW_READY = W_READY = 0. Incoming requests wait and are never dropped.
- There is no error response channel. Out-of-range accesses complete normally.

## Timing
- Reset values: state IDLE; R_VALID 0; B_VALID 0; R_DATA 64'h0; counter 0. Array contents are not cleared by reset.
- Ready outputs are combinational from state and valids. R_VALID, B_VALID and R_DATA are registered.
- Read latency: if AR is handshaken at edge N, R_VALID is high in the cycle after edge N+RD_LATENCY-1, i.e. RD_LATENCY cycles after the request cycle.
- Write latency: B_VALID rises WR_LATENCY cycles after the handshake cycle.
- Throughput: the earliest next AR_READY is the cycle after the R handshake. Minimum read period is RD_LATENCY+1 cycles.
- Read-after-write: a read accepted after B completes returns the merged data.
- AR_VALID and AW_VALID high together in IDLE:
  - The read is taken.
  - The write waits.
  - The write is taken in the first IDLE cycle where AR_VALID is low.
- Reset asserted mid-transaction:
  - Next cycle: IDLE, R_VALID=B_VALID=0.
  - The pending response is discarded.
  - A write already committed to the array stays committed.

## Test plan
- Write then read back:
  - Write addr 0x8000_0010, data 0x1122334455667788, strobe 0xFF. B_VALID comes 1 cycle after the handshake.
  - Read 0x8000_0010. R_DATA = 0x1122334455667788 exactly RD_LATENCY=2 cycles after the AR cycle.
- Byte strobes: write 0xAAAAAAAAAAAAAAAA with strobe 0x0F over that word, then read -> 0x11223344AAAAAAAA. Read of 0x8000_0014 returns the same word.
- Backpressure:
  - Hold R_READY=0 for 5 cycles with R_VALID high. R_DATA stays stable and AR_READY stays 0 throughout.
  - Raise R_READY. R_VALID drops next cycle and AR_READY=1.
- Simultaneous requests: AR_VALID and AW/W_VALID asserted in the same IDLE cycle -> the read completes first. The write is accepted only after AR_VALID deasserts, and B_VALID follows.
- Out of range:
  - Read 0x7FFF_FFF8 -> R_DATA=0.
  - Write 0x8000_8000 (DEPTH 4096) -> B_VALID still asserted and no array word changes.
- Reset mid-read: assert rst_n=0 in RD_WAIT -> R_VALID never rises for that request. After release, AR_READY=1 and a new read returns correct data.
